// File: rtl/vga_pkg.sv
// vga_pkg: shared timing parameter-set type, standard mode presets and line/frame total helper
package vga_pkg;
  typedef struct packed {
    int unsigned h_active, h_fp, h_sync, h_bp;
    int unsigned v_active, v_fp, v_sync, v_bp;
    bit          hs_pol, vs_pol;
  } vga_timing_t;
  localparam vga_timing_t VGA_640x480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam vga_timing_t SVGA_800x600_60 = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  function automatic int unsigned vga_total(int unsigned active, int unsigned fp, int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster bus; master drives pix_en/resync and reads syncs, blanking, coordinates and strobes; slave is the generator
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic          pix_en, resync;
  logic          vga_hsync, vga_vsync, inDisplayArea, hblank, vblank, line_start, frame_start;
  logic [CW-1:0] CounterX, CounterY;
  modport master (
    output pix_en, resync,
    input  vga_hsync, vga_vsync, inDisplayArea, hblank, vblank, CounterX, CounterY, line_start, frame_start
  );
  modport slave (
    input  pix_en, resync,
    output vga_hsync, vga_vsync, inDisplayArea, hblank, vblank, CounterX, CounterY, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; clk/rst_n, enable/clear/wrap_in in; count, wrap_out, active, sync (at POL) out
module vga_axis_counter #(
  parameter int CW     = 12,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clear,
  input  logic          wrap_in,
  output logic [CW-1:0] count,
  output logic          wrap_out,
  output logic          active,
  output logic          sync
);
  localparam logic [CW-1:0] LAST   = CW'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CW-1:0] ACT    = CW'(ACTIVE);
  localparam logic [CW-1:0] S_FIRST = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] S_LAST  = CW'(ACTIVE + FP + SYNC - 1);
  assign wrap_out = wrap_in && count == LAST;
  assign active   = count < ACT;
  assign sync     = (count >= S_FIRST && count <= S_LAST) ? POL : ~POL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable && wrap_in) count <= wrap_out ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing; vga_clk/vga_rst_n plus slave bus (pix_en, resync in; syncs, blanking, CounterX/Y, strobes out)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input logic             vga_clk,
  input logic             vga_rst_n,
  vga_timing_gen_if.slave bus
);
  localparam int H_TOTAL = int'(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int V_TOTAL = int'(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int OW      = 2 * CW + 7;
  localparam logic [OW-1:0] RST_OUT = {~HS_POL, ~VS_POL, 3'b011, {(2 * CW + 2){1'b0}}};
  if (H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW) begin : g_range
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter width CW");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero
    $error("vga_timing_gen: timing fields must be non-zero");
  end
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, unused_v_wrap, h_act, v_act, h_sync, v_sync;
  logic [OW-1:0] out_q, out_d;
  vga_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h (
    .clk(vga_clk), .rst_n(vga_rst_n), .enable(bus.pix_en), .clear(bus.resync), .wrap_in(1'b1),
    .count(h_cnt), .wrap_out(h_wrap), .active(h_act), .sync(h_sync)
  );
  vga_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v (
    .clk(vga_clk), .rst_n(vga_rst_n), .enable(bus.pix_en), .clear(bus.resync), .wrap_in(h_wrap),
    .count(v_cnt), .wrap_out(unused_v_wrap), .active(v_act), .sync(v_sync)
  );
  // Output word describes the pixel the counters hold now; it lands one enabled edge later.
  always_comb
    out_d = bus.resync ? RST_OUT :
            bus.pix_en ? {h_sync, v_sync, h_act && v_act, ~h_act, ~v_act, h_cnt, v_cnt,
                          h_cnt == '0, h_cnt == '0 && v_cnt == '0} : out_q;
  always_ff @(posedge vga_clk or negedge vga_rst_n)
    if (!vga_rst_n) out_q <= RST_OUT;
    else out_q <= out_d;
  assign {bus.vga_hsync, bus.vga_vsync, bus.inDisplayArea, bus.hblank, bus.vblank,
          bus.CounterX, bus.CounterY, bus.line_start, bus.frame_start} = out_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for a default 640x480 instance and a tiny 8x5 instance
module tb_vga_timing_gen;
  typedef struct packed {
    logic        hs, vs, de, hb, vb;
    logic [11:0] x, y;
    logic        ls, fs;
  } px_t;
  typedef struct packed {
    px_t  a, b;
    logic cnt_a, cnt_b, fin;
  } item_t;
  localparam px_t RST_A = '{hs: 1'b1, vs: 1'b1, de: 1'b0, hb: 1'b1, vb: 1'b1, x: 12'd0, y: 12'd0, ls: 1'b0, fs: 1'b0};
  localparam px_t RST_B = '{hs: 1'b0, vs: 1'b0, de: 1'b0, hb: 1'b1, vb: 1'b1, x: 12'd0, y: 12'd0, ls: 1'b0, fs: 1'b0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vga_timing_gen_if #(.CW(12)) ia ();
  vga_timing_gen_if #(.CW(12)) ib ();
  vga_timing_gen #(.CW(12)) dut_a (.vga_clk(clk), .vga_rst_n(rst_n), .bus(ia));
  vga_timing_gen #(
    .CW(12), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (.vga_clk(clk), .vga_rst_n(rst_n), .bus(ib));
  item_t q[$];
  int checks = 0, failures = 0;
  int ha = 0, va = 0, hb = 0, vb = 0;
  px_t oa = RST_A, ob = RST_B;
  int hs_low_a = 0, de_a = 0, ls_a = 0, fs_b = 0, vs_b = 0, hs_b = 0, de_b = 0;
  function automatic px_t pix_a(int h, int v);
    px_t p;
    p.hs = !(h >= 656 && h <= 751);
    p.vs = !(v >= 490 && v <= 491);
    p.de = h < 640 && v < 480;
    p.hb = h >= 640;
    p.vb = v >= 480;
    p.x  = 12'(h);
    p.y  = 12'(v);
    p.ls = h == 0;
    p.fs = h == 0 && v == 0;
    return p;
  endfunction
  function automatic px_t pix_b(int h, int v);
    px_t p;
    p.hs = h == 5 || h == 6;
    p.vs = v == 3;
    p.de = h < 4 && v < 2;
    p.hb = h >= 4;
    p.vb = v >= 2;
    p.x  = 12'(h);
    p.y  = 12'(v);
    p.ls = h == 0;
    p.fs = h == 0 && v == 0;
    return p;
  endfunction
  function automatic string fmt(px_t p);
    return $sformatf("hs%b vs%b de%b hb%b vb%b x%0d y%0d ls%b fs%b",
                     p.hs, p.vs, p.de, p.hb, p.vb, p.x, p.y, p.ls, p.fs);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic step(bit rst, bit pe, bit rs, bit ca = 1'b0, bit cb = 1'b0, bit fin = 1'b0);
    item_t it;
    @(negedge clk);
    rst_n = !rst;
    ia.pix_en = pe;
    ib.pix_en = pe;
    ia.resync = rs;
    ib.resync = rs;
    if (rst || rs) begin
      oa = RST_A; ob = RST_B;
      ha = 0; va = 0; hb = 0; vb = 0;
    end else if (pe) begin
      oa = pix_a(ha, va);
      ob = pix_b(hb, vb);
      if (ha == 799) begin ha = 0; va = (va == 524) ? 0 : va + 1; end else ha++;
      if (hb == 7) begin hb = 0; vb = (vb == 4) ? 0 : vb + 1; end else hb++;
    end
    it.a = oa; it.b = ob; it.cnt_a = ca; it.cnt_b = cb; it.fin = fin;
    q.push_back(it);
  endtask
  always @(posedge clk) begin : monitor
    item_t it;
    px_t da, db;
    #1;
    if (q.size() > 0) begin
      it = q.pop_front();
      da = {ia.vga_hsync, ia.vga_vsync, ia.inDisplayArea, ia.hblank, ia.vblank,
            ia.CounterX, ia.CounterY, ia.line_start, ia.frame_start};
      db = {ib.vga_hsync, ib.vga_vsync, ib.inDisplayArea, ib.hblank, ib.vblank,
            ib.CounterX, ib.CounterY, ib.line_start, ib.frame_start};
      checks++;
      if (da !== it.a) begin
        failures++;
        $display("FAIL pix_640 @%0t: got %s, expected %s", $time, fmt(da), fmt(it.a));
      end
      checks++;
      if (db !== it.b) begin
        failures++;
        $display("FAIL pix_tiny @%0t: got %s, expected %s", $time, fmt(db), fmt(it.b));
      end
      if (it.cnt_a) begin
        hs_low_a += int'(!da.hs); de_a += int'(da.de); ls_a += int'(da.ls);
      end
      if (it.cnt_b) begin
        fs_b += int'(db.fs); vs_b += int'(db.vs); hs_b += int'(db.hs); de_b += int'(db.de);
      end
      if (it.fin) begin
        chk("hsync_low_clocks_per_line", hs_low_a, 96);
        chk("display_clocks_per_line", de_a, 640);
        chk("line_starts_per_line", ls_a, 1);
        chk("tiny_frame_starts_3frames", fs_b, 3);
        chk("tiny_vsync_clocks_3frames", vs_b, 24);
        chk("tiny_hsync_clocks_3frames", hs_b, 30);
        chk("tiny_display_clocks_3frames", de_b, 24);
      end
    end
  end
  initial begin
    ia.pix_en = 1'b0; ia.resync = 1'b0;
    ib.pix_en = 1'b0; ib.resync = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 1600; i++) step(1'b0, 1'b1, 1'b0, i < 800, i < 120, i == 900);
    for (int i = 0; i < 1600; i++) step(1'b0, i % 2 == 0, 1'b0);
    for (int i = 0; i < 2000 && oa.x != 12'd300; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 123; i++) step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator. Successor to the fixed 640x480 sync block.
- Every timing field and sync polarity is a parameter, and all outputs come from one registered stage.
- Adds a pixel clock-enable, synchronous resync, blanking flags, and line/frame start strobes.
- Sits between the pixel-clock domain and the pixel/framebuffer pipeline; drives the VGA connector syncs directly.

Parameters:
- CW, 12, width of counters and coordinate outputs.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (clocks).
- H_SYNC, 96, horizontal sync width (clocks).
- H_BP, 48, horizontal back porch (clocks).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- HS_POL, 0, active level of vga_hsync (0 = active-low).
- VS_POL, 0, active level of vga_vsync.

Ports:
- vga_clk, input, 1, pixel clock.
- vga_rst_n, input, 1, asynchronous active-low reset.
- pix_en, input, 1, clock enable; one pixel is advanced per vga_clk edge with pix_en=1.
- resync, input, 1, synchronous restart of the raster at (0,0).
- vga_hsync, output, 1, horizontal sync at HS_POL polarity.
- vga_vsync, output, 1, vertical sync at VS_POL polarity.
- inDisplayArea, output, 1, pixel is inside the active region.
- hblank, output, 1, horizontal counter outside active.
- vblank, output, 1, vertical counter outside active.
- CounterX, output, CW, horizontal position of the current output pixel.
- CounterY, output, CW, vertical position of the current output pixel.
- line_start, output, 1, one-enable pulse when CounterX=0.
- frame_start, output, 1, one-enable pulse when CounterX=0 and CounterY=0.

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Elaboration error unless H_TOTAL <= 2**CW and V_TOTAL <= 2**CW.
  - Elaboration error if any field is 0.
- Internal counters h_cnt and v_cnt:
  - h_cnt runs 0..H_TOTAL-1; after H_TOTAL-1 it wraps to 0. Line period is exactly H_TOTAL enables.
  - v_cnt increments only on an h_cnt wrap.
  - v_cnt runs 0..V_TOTAL-1, then wraps to 0.
- Output stage:
  - All outputs are registered from the current h_cnt/v_cnt on the same enabled edge that advances the counters. Outputs therefore describe pixel (h_cnt,v_cnt) one edge after the counters held those values.
  - inDisplayArea = h<H_ACTIVE and v<V_ACTIVE.
  - hblank = h>=H_ACTIVE; vblank = v>=V_ACTIVE.
  - hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. exactly H_SYNC clocks.
  - vsync is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. exactly V_SYNC lines, transitioning on h wrap.
  - CounterX and CounterY are h and v.
  - line_start = (h==0); frame_start = (h==0 and v==0).
- pix_en=0: counters and all outputs hold. Strobes also hold, so a strobe is one enabled pixel wide, not one clock.
- resync=1 (sampled on vga_clk, priority over pix_en):
  - h_cnt and v_cnt are loaded to 0.
  - Outputs are loaded to reset values.
  - The next enabled edge after resync deasserts emits pixel (0,0) with frame_start=1.
- Reset (asynchronous assert, any time including mid-frame):
  - h_cnt, v_cnt, CounterX, CounterY = 0.
  - inDisplayArea = 0, line_start = 0, frame_start = 0.
  - hblank = 1, vblank = 1.
  - vga_hsync = ~HS_POL, vga_vsync = ~VS_POL.
  - First enabled edge after release produces pixel (0,0): inDisplayArea=1, line_start=1, frame_start=1.
- No combinational path from any input to any output.

Decomposition:
- Shared package vga_pkg holds:
  - a typedef for the timing parameter set;
  - localparam presets for VGA_640x480_60 and SVGA_800x600_60;
  - an H_TOTAL/V_TOTAL helper function.
- One natural sub-module, vga_axis_counter:
  - parameters ACTIVE/FP/SYNC/BP/POL;
  - inputs: enable, clear, wrap_in;
  - outputs: count, wrap_out, active, sync.
- vga_timing_gen instantiates two vga_axis_counter instances:
  - horizontal instance with wrap_in tied 1;
  - vertical instance with wrap_in = horizontal wrap.

Test Plan:
1. Defaults, pix_en=1, reset released → first edge gives CounterX=0, CounterY=0, inDisplayArea=1, frame_start=1. frame_start recurs exactly every 800*525=420000 clocks.
2. Defaults, one line → vga_hsync low for exactly 96 clocks, starting when CounterX=656 and ending after CounterX=751. inDisplayArea high for 640 clocks; line_start period 800.
3. Defaults, full frame → vga_vsync low during CounterY=490..491 only (1600 clocks). vblank high for CounterY 480..524.
4. pix_en toggled 1/0 every clock → all periods double: line_start every 1600 clocks. Outputs hold during pix_en=0, and frame_start stays high for 2 clocks.
5. resync pulsed at CounterX=300, CounterY=200, with pix_en=0 on that edge → next edge outputs are at reset values, the following edge gives (0,0) with frame_start=1. Async vga_rst_n pulse mid-line → same recovery.
6. Small config: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, HS_POL=VS_POL=1 → CounterX sequence 0..7; hsync high only at CounterX 5,6; vsync high only at CounterY=3; frame period 40 clocks.
